execute_stage_pipe: RTL and testbench
=====================================

// Module: execute_stage_pipe
// PURPOSE
//  Parametrised execute stage with an EX/MEM output register. Runs the ALU on op1/op2,
//  including an iterative multi-cycle MUL, and registers the result, Z/N/C flags and the
//  decode sideband (reg-write, write address, sign-extend, wb select, read data, mem ctrl).
//  Uses valid/ready handshakes on both sides so the memory stage can stall it.
//  Has a synchronous flush for branch/hazard kill. Sits between decode and memory stages.
// PARAMETERS
//  DATA_W  16  datapath width: operands, result, sign-extend, read data
//  REG_AW  3   register-file address width
//  MUL_EN  1   1: mode 110 is iterative MUL; 0: mode 110 behaves as PASS op2
// PORTS
//  clk             in   1       clock, rising edge
//  reset           in   1       synchronous, active-low reset
//  in_valid        in   1       decode presents a valid op
//  in_ready        out  1       stage accepts op this cycle
//  op1, op2        in   DATA_W  ALU operands
//  alu_mode        in   3       ALU operation (see BEHAVIOUR)
//  reg_write       in   1       sideband, passed through (likewise the next 6 inputs)
//  reg_waddr       in   REG_AW
//  sign_ext        in   DATA_W
//  wb_sel          in   1
//  rd_data1        in   DATA_W
//  rd_data2        in   DATA_W
//  mem_read        in   1
//  mem_write       in   1
//  flush           in   1       kill in-flight and buffered op
//  out_valid       out  1       EX/MEM register holds a valid op
//  out_ready       in   1       memory stage consumes it this cycle
//  result_r        out  DATA_W  ALU result
//  flags_r         out  3       {Z,N,C} of result_r
//  *_r             out  -       registered copies of every sideband input, same widths
// BEHAVIOUR
//  Reset (reset==0 at clk edge): all outputs 0, FSM->IDLE, mul counter 0; in_ready=0 while reset low.
//  ALU modes:
//   000 ADD   C = carry out
//   001 SUB   op1-op2; C = borrow (op1<op2 unsigned)
//   010 AND
//   011 OR
//   100 NOT op1
//   101 SHL   op1 << op2[$clog2(DATA_W)-1:0]; C = last bit out, 0 if shift 0
//   110 MUL   low DATA_W bits of unsigned product
//   111 PASS op2
//  C=0 for modes not listed with C. Z = result==0. N = result[DATA_W-1].
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
//  FSM states:
//   IDLE: single-cycle op accepted -> result/flags/sideband loaded, out_valid=1 next cycle
//         (latency 1). Throughput 1/cycle when out_ready=1.
//         MUL accepted -> operands + sideband latched, counter=0, -> MUL.
//   MUL:  one shift-add step per cycle; after DATA_W steps -> DONE. in_ready=0.
//   DONE: if !out_valid | out_ready, load EX/MEM reg (out_valid=1 next cycle) -> IDLE; else hold.
//   MUL accept-to-out_valid latency = DATA_W+2 cycles when output is free.
//  Stall: out_valid & !out_ready -> every *_r output held stable.
//   out_valid & out_ready & accept in same cycle -> register replaced, out_valid stays 1.
//  Flush (priority below reset, above everything else): next cycle out_valid=0,
//   FSM->IDLE, MUL aborted, in_ready=0 during flush cycle. Data regs may keep stale values.
//  Reset mid-MUL: aborts identically to flush; all outputs to 0.
//  Unused arithmetic bits beyond DATA_W are discarded; no saturation.
// TESTING
//  Reset low 2 cycles -> all outputs 0, in_ready 0; release -> in_ready 1.
//  ADD 0xFFFF+0x0001 -> next cycle result_r 0x0000, flags_r 3'b101, out_valid 1.
//  SUB 0x0003-0x0005 -> result_r 0xFFFE, flags_r 3'b011; sideband reg_waddr 5 appears as reg_waddr_r 5.
//  MUL 0x0012*0x0034 (DATA_W=16) -> out_valid after 18 cycles, result_r 0x03A8; in_ready 0 throughout.
//  out_ready=0 for 3 cycles with out_valid=1 -> result_r/sideband stable, in_ready 0;
//   then back-to-back ADDs with out_ready=1 -> one result per cycle.
//  flush asserted at MUL cycle 5 -> out_valid stays 0, FSM IDLE, next ADD completes in 1 cycle.

Source files
------------

// File: rtl/execute_stage_pipe_if.sv
// Decode-to-memory bus of the execute stage: op/sideband in, EX/MEM register out.
// master drives the op side and consumes results; slave is the execute stage itself.
interface execute_stage_pipe_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic [2:0]        alu_mode;
   logic              reg_write;
   logic [REG_AW-1:0] reg_waddr;
   logic [DATA_W-1:0] sign_ext;
   logic              wb_sel;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              mem_read;
   logic              mem_write;
   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result_r;
   logic [2:0]        flags_r;
   logic              reg_write_r;
   logic [REG_AW-1:0] reg_waddr_r;
   logic [DATA_W-1:0] sign_ext_r;
   logic              wb_sel_r;
   logic [DATA_W-1:0] rd_data1_r;
   logic [DATA_W-1:0] rd_data2_r;
   logic              mem_read_r;
   logic              mem_write_r;

   modport master (
      output in_valid, op1, op2, alu_mode, reg_write, reg_waddr, sign_ext, wb_sel,
             rd_data1, rd_data2, mem_read, mem_write, flush, out_ready,
      input  in_ready, out_valid, result_r, flags_r, reg_write_r, reg_waddr_r, sign_ext_r,
             wb_sel_r, rd_data1_r, rd_data2_r, mem_read_r, mem_write_r
   );

   modport slave (
      input  in_valid, op1, op2, alu_mode, reg_write, reg_waddr, sign_ext, wb_sel,
             rd_data1, rd_data2, mem_read, mem_write, flush, out_ready,
      output in_ready, out_valid, result_r, flags_r, reg_write_r, reg_waddr_r, sign_ext_r,
             wb_sel_r, rd_data1_r, rd_data2_r, mem_read_r, mem_write_r
   );
endinterface

// File: rtl/execute_stage_pipe.sv
// Execute stage: ALU plus iterative shift-add MUL feeding an EX/MEM register; latency 1 (MUL DATA_W+2).
// Backpressure: EX/MEM register holds while out_valid & !out_ready; in_ready drops while busy or flushed.
module execute_stage_pipe #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int MUL_EN = 1
) (
   input logic                  clk,
   input logic                  reset,
   execute_stage_pipe_if.slave  bus
);
   localparam int SH_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   typedef struct packed {
      logic              reg_write;
      logic [REG_AW-1:0] reg_waddr;
      logic [DATA_W-1:0] sign_ext;
      logic              wb_sel;
      logic [DATA_W-1:0] rd_data1;
      logic [DATA_W-1:0] rd_data2;
      logic              mem_read;
      logic              mem_write;
   } side_t;

   state_t            state;
   logic [SH_W-1:0]   mul_cnt;
   logic [DATA_W-1:0] mul_a, mul_b, mul_acc;
   side_t             mul_side, side_in, side_r;
   logic              out_valid;
   logic [DATA_W-1:0] result_r;
   logic [2:0]        flags_r;

   logic              in_ready, accept, is_mul, alu_c;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W:0]   wide;

   assign side_in = '{reg_write: bus.reg_write, reg_waddr: bus.reg_waddr,
                      sign_ext: bus.sign_ext, wb_sel: bus.wb_sel,
                      rd_data1: bus.rd_data1, rd_data2: bus.rd_data2,
                      mem_read: bus.mem_read, mem_write: bus.mem_write};

   assign in_ready = reset && (state == IDLE) && (!out_valid || bus.out_ready) && !bus.flush;
   assign accept   = bus.in_valid && in_ready;
   assign is_mul   = (MUL_EN != 0) && (bus.alu_mode == 3'b110);

   // The extra top bit of 'wide' carries ADD carry-out and the last bit shifted out by SHL.
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      wide    = '0;
      case (bus.alu_mode)
         3'b000: begin
            wide    = {1'b0, bus.op1} + {1'b0, bus.op2};
            alu_res = wide[DATA_W-1:0];
            alu_c   = wide[DATA_W];
         end
         3'b001: begin
            alu_res = bus.op1 - bus.op2;
            alu_c   = bus.op1 < bus.op2;
         end
         3'b010: alu_res = bus.op1 & bus.op2;
         3'b011: alu_res = bus.op1 | bus.op2;
         3'b100: alu_res = ~bus.op1;
         3'b101: begin
            wide    = {1'b0, bus.op1} << bus.op2[SH_W-1:0];
            alu_res = wide[DATA_W-1:0];
            alu_c   = wide[DATA_W];
         end
         default: alu_res = bus.op2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mul_cnt   <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_acc   <= '0;
         mul_side  <= '0;
         side_r    <= '0;
         out_valid <= 1'b0;
         result_r  <= '0;
         flags_r   <= '0;
      end else if (bus.flush) begin
         state     <= IDLE;
         mul_cnt   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && bus.out_ready) out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && is_mul) begin
                  mul_a    <= bus.op1;
                  mul_b    <= bus.op2;
                  mul_acc  <= '0;
                  mul_cnt  <= '0;
                  mul_side <= side_in;
                  state    <= MUL;
               end else if (accept) begin
                  result_r  <= alu_res;
                  flags_r   <= {alu_res == '0, alu_res[DATA_W-1], alu_c};
                  side_r    <= side_in;
                  out_valid <= 1'b1;
               end
            end
            MUL: begin
               if (mul_b[0]) mul_acc <= mul_acc + mul_a;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               mul_cnt <= mul_cnt + 1'b1;
               if (mul_cnt == SH_W'(DATA_W - 1)) state <= DONE;
            end
            DONE: begin
               if (!out_valid || bus.out_ready) begin
                  result_r  <= mul_acc;
                  flags_r   <= {mul_acc == '0, mul_acc[DATA_W-1], 1'b0};
                  side_r    <= mul_side;
                  out_valid <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.result_r    = result_r;
   assign bus.flags_r     = flags_r;
   assign bus.reg_write_r = side_r.reg_write;
   assign bus.reg_waddr_r = side_r.reg_waddr;
   assign bus.sign_ext_r  = side_r.sign_ext;
   assign bus.wb_sel_r    = side_r.wb_sel;
   assign bus.rd_data1_r  = side_r.rd_data1;
   assign bus.rd_data2_r  = side_r.rd_data2;
   assign bus.mem_read_r  = side_r.mem_read;
   assign bus.mem_write_r = side_r.mem_write;
endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed bench for execute_stage_pipe (DATA_W=16): reset, ALU flags, sideband, MUL latency,
// stall hold, back-to-back throughput and flush of an in-flight MUL.
module tb_execute_stage_pipe;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   lat;

   execute_stage_pipe_if #(.DATA_W(16), .REG_AW(3)) bus ();

   execute_stage_pipe #(.DATA_W(16), .REG_AW(3), .MUL_EN(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] m,
                         input logic [2:0] wa);
      bus.op1       = a;
      bus.op2       = b;
      bus.alu_mode  = m;
      bus.reg_waddr = wa;
   endtask

   initial begin
      reset = 1'b0;
      bus.in_valid = 0; bus.op1 = 0; bus.op2 = 0; bus.alu_mode = 0;
      bus.reg_write = 0; bus.reg_waddr = 0; bus.sign_ext = 0; bus.wb_sel = 0;
      bus.rd_data1 = 0; bus.rd_data2 = 0; bus.mem_read = 0; bus.mem_write = 0;
      bus.flush = 0; bus.out_ready = 1;

      step(); step();
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_result", 32'(bus.result_r), 0);
      chk("rst_flags", 32'(bus.flags_r), 0);
      chk("rst_waddr", 32'(bus.reg_waddr_r), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      reset = 1'b1;
      #1;
      chk("rel_in_ready", 32'(bus.in_ready), 1);

      // ADD with wrap: Z and C set
      bus.in_valid = 1;
      set_op(16'hFFFF, 16'h0001, 3'b000, 3'd2);
      step();
      chk("add_valid", 32'(bus.out_valid), 1);
      chk("add_result", 32'(bus.result_r), 32'h0000);
      chk("add_flags", 32'(bus.flags_r), 32'b101);

      // SUB with borrow plus sideband
      set_op(16'h0003, 16'h0005, 3'b001, 3'd5);
      bus.reg_write = 1; bus.rd_data1 = 16'hABCD; bus.mem_write = 1;
      step();
      chk("sub_result", 32'(bus.result_r), 32'hFFFE);
      chk("sub_flags", 32'(bus.flags_r), 32'b011);
      chk("sub_waddr", 32'(bus.reg_waddr_r), 5);
      chk("sub_rd1", 32'(bus.rd_data1_r), 32'hABCD);
      chk("sub_wr", 32'(bus.reg_write_r), 1);
      chk("sub_memw", 32'(bus.mem_write_r), 1);

      // MUL 0x12*0x34: 18 edges from accept to out_valid, in_ready low meanwhile
      bus.reg_write = 0; bus.mem_write = 0;
      set_op(16'h0012, 16'h0034, 3'b110, 3'd7);
      step();
      bus.in_valid = 0;
      lat = 1;
      chk("mul_start_valid", 32'(bus.out_valid), 0);
      while (!bus.out_valid && lat < 40) begin
         chk("mul_in_ready", 32'(bus.in_ready), 0);
         step();
         lat++;
      end
      chk("mul_latency", 32'(lat), 18);
      chk("mul_result", 32'(bus.result_r), 32'h03A8);
      chk("mul_flags", 32'(bus.flags_r), 0);
      chk("mul_waddr", 32'(bus.reg_waddr_r), 7);

      // Stall three cycles with a new op waiting
      bus.out_ready = 0;
      bus.in_valid = 1;
      set_op(16'h0001, 16'h0002, 3'b000, 3'd1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 32'(bus.in_ready), 0);
         step();
         chk("stall_valid", 32'(bus.out_valid), 1);
         chk("stall_result", 32'(bus.result_r), 32'h03A8);
         chk("stall_waddr", 32'(bus.reg_waddr_r), 7);
      end
      bus.out_ready = 1;
      #1;
      chk("unstall_in_ready", 32'(bus.in_ready), 1);

      // Back-to-back single-cycle ops, one result per edge
      step();
      chk("b2b0_valid", 32'(bus.out_valid), 1);
      chk("b2b0_result", 32'(bus.result_r), 32'h0003);
      chk("b2b0_waddr", 32'(bus.reg_waddr_r), 1);
      set_op(16'h8001, 16'h0001, 3'b101, 3'd3);
      step();
      chk("b2b1_result", 32'(bus.result_r), 32'h0002);
      chk("b2b1_flags", 32'(bus.flags_r), 32'b001);
      chk("b2b1_waddr", 32'(bus.reg_waddr_r), 3);
      set_op(16'h7FFF, 16'h0001, 3'b000, 3'd4);
      step();
      chk("b2b2_result", 32'(bus.result_r), 32'h8000);
      chk("b2b2_flags", 32'(bus.flags_r), 32'b010);
      chk("b2b2_valid", 32'(bus.out_valid), 1);

      // Flush at MUL cycle 5
      set_op(16'h0003, 16'h0004, 3'b110, 3'd6);
      step();
      bus.in_valid = 0;
      for (int i = 0; i < 4; i++) step();
      bus.flush = 1;
      #1;
      chk("flush_in_ready", 32'(bus.in_ready), 0);
      step();
      bus.flush = 0;
      #1;
      chk("flush_valid", 32'(bus.out_valid), 0);
      chk("flush_idle_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1;
      set_op(16'h0005, 16'h0006, 3'b000, 3'd2);
      step();
      bus.in_valid = 0;
      chk("post_flush_valid", 32'(bus.out_valid), 1);
      chk("post_flush_result", 32'(bus.result_r), 32'h000B);
      chk("post_flush_waddr", 32'(bus.reg_waddr_r), 2);
      step();
      chk("drain_valid", 32'(bus.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
